// File: rtl/leaf_pkg.sv
// leaf_pkg: shared constants and start-FSM encoding for the leaf user-side adapter
package leaf_pkg;
    localparam int LEAF_PAYLOAD_BITS = 32;
    localparam int START_EXT = 0;
    localparam int START_AUTO = 1;
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} start_state_t;
endpackage

// File: rtl/leaf_user_adapter_if.sv
// leaf_user_adapter_if: stream bundle between leaf_interface, the adapter and the operator
//   slave  = adapter side, master = environment (leaf_interface + operator) side
//   in streams : dout_leaf_interface2user/vld_interface2user/ack_user2interface -> op_in_data/op_in_vld/op_in_ack
//   out streams: op_out_data/op_out_vld/op_out_ack -> din_leaf_user2interface/vld_user2interface/ack_interface2user
//   in_level/out_level: per-FIFO occupancy, DEPTH_LOG2+1 bits each
interface leaf_user_adapter_if
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS = 2,
    parameter int NUM_OUT_PORTS = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
);
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic [NUM_IN_PORTS-1:0] vld_interface2user;
    logic [NUM_IN_PORTS-1:0] ack_user2interface;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] op_in_data;
    logic [NUM_IN_PORTS-1:0] op_in_vld;
    logic [NUM_IN_PORTS-1:0] op_in_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] op_out_data;
    logic [NUM_OUT_PORTS-1:0] op_out_vld;
    logic [NUM_OUT_PORTS-1:0] op_out_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0] vld_user2interface;
    logic [NUM_OUT_PORTS-1:0] ack_interface2user;
    logic [NUM_IN_PORTS*(FIFO_DEPTH_LOG2+1)-1:0] in_level;
    logic [NUM_OUT_PORTS*(FIFO_DEPTH_LOG2+1)-1:0] out_level;
    modport slave (
        input dout_leaf_interface2user, vld_interface2user, op_in_ack,
        input op_out_data, op_out_vld, ack_interface2user,
        output ack_user2interface, op_in_data, op_in_vld,
        output op_out_ack, din_leaf_user2interface, vld_user2interface,
        output in_level, out_level
    );
    modport master (
        output dout_leaf_interface2user, vld_interface2user, op_in_ack,
        output op_out_data, op_out_vld, ack_interface2user,
        input ack_user2interface, op_in_data, op_in_vld,
        input op_out_ack, din_leaf_user2interface, vld_user2interface,
        input in_level, out_level
    );
endinterface

// File: rtl/leaf_hs_fifo.sv
// leaf_hs_fifo: first-word-fall-through ap_hs FIFO with occupancy output
//   clk, rst (sync clear), din/in_vld/in_ack write side, dout/out_vld/out_ack read side, level 0..2**DEPTH_LOG2
module leaf_hs_fifo
    import leaf_pkg::*;
#(
    parameter int WIDTH = LEAF_PAYLOAD_BITS,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  in_vld,
    output logic                  in_ack,
    output logic [WIDTH-1:0]      dout,
    output logic                  out_vld,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   level
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic [DEPTH_LOG2:0] cnt;
    logic wr, rd;
    // Count never exceeds depth, so its MSB alone marks full.
    assign in_ack = !cnt[DEPTH_LOG2];
    assign out_vld = cnt != '0;
    assign dout = mem[rp];
    assign level = cnt;
    assign wr = in_vld && in_ack;
    assign rd = out_vld && out_ack;
    always_ff @(posedge clk)
        if (wr && !rst) mem[wp] <= din;
    always_ff @(posedge clk)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + DEPTH_LOG2'(wr);
            rp <= rp + DEPTH_LOG2'(rd);
            cnt <= cnt + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
        end
endmodule

// File: rtl/leaf_user_adapter.sv
// leaf_user_adapter: per-port FIFO decoupling plus operator start control between leaf_interface and an HLS operator
//   clk, reset (sync), flush (sync clear), ap_start (external start, START_MODE=0),
//   op_ap_start/op_ap_done operator control, u = stream bundle (slave side)
module leaf_user_adapter
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS = 2,
    parameter int NUM_OUT_PORTS = 1,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int START_MODE = START_AUTO
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic ap_start,
    input  logic op_ap_done,
    output logic op_ap_start,
    leaf_user_adapter_if.slave u
);
    localparam int P = PAYLOAD_BITS;
    localparam int LW = FIFO_DEPTH_LOG2 + 1;
    logic clr;
    start_state_t state;
    assign clr = reset || flush;
    for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
        leaf_hs_fifo #(.WIDTH(P), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) fifo (
            .clk(clk), .rst(clr),
            .din(u.dout_leaf_interface2user[k*P +: P]), .in_vld(u.vld_interface2user[k]), .in_ack(u.ack_user2interface[k]),
            .dout(u.op_in_data[k*P +: P]), .out_vld(u.op_in_vld[k]), .out_ack(u.op_in_ack[k]),
            .level(u.in_level[k*LW +: LW])
        );
    end
    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        leaf_hs_fifo #(.WIDTH(P), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) fifo (
            .clk(clk), .rst(clr),
            .din(u.op_out_data[k*P +: P]), .in_vld(u.op_out_vld[k]), .in_ack(u.op_out_ack[k]),
            .dout(u.din_leaf_user2interface[k*P +: P]), .out_vld(u.vld_user2interface[k]), .out_ack(u.ack_interface2user[k]),
            .level(u.out_level[k*LW +: LW])
        );
    end
    // Auto mode fires once every input head is valid; returning to IDLE lets it re-fire on the following cycle.
    always_ff @(posedge clk)
        if (clr) begin
            state <= S_IDLE;
            op_ap_start <= 1'b0;
        end else if (START_MODE == START_EXT) begin
            state <= S_IDLE;
            op_ap_start <= ap_start;
        end else if (state == S_IDLE) begin
            if (&u.op_in_vld) begin
                state <= S_RUN;
                op_ap_start <= 1'b1;
            end
        end else if (op_ap_done) begin
            state <= S_IDLE;
            op_ap_start <= 1'b0;
        end
endmodule

// File: tb/tb_leaf_user_adapter.sv
// tb_leaf_user_adapter: directed self-checking bench for leaf_user_adapter (default parameters, auto-start)
module tb_leaf_user_adapter;
    import leaf_pkg::*;
    logic clk, reset, flush, ap_start, op_ap_done, op_ap_start;
    int errors = 0;
    int checks = 0;
    leaf_user_adapter_if #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1), .FIFO_DEPTH_LOG2(4)) bus ();
    leaf_user_adapter #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1), .FIFO_DEPTH_LOG2(4), .START_MODE(START_AUTO)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ap_start(ap_start),
        .op_ap_done(op_ap_done), .op_ap_start(op_ap_start), .u(bus.slave)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        reset = 1;
        repeat (3) tick();
        reset = 0;
        checks++; if (bus.ack_user2interface !== 2'b11) begin errors++; $display("FAIL reset_in_ack got=%b exp=11", bus.ack_user2interface); end
        checks++; if (bus.op_out_ack !== 1'b1) begin errors++; $display("FAIL reset_out_ack got=%b exp=1", bus.op_out_ack); end
        checks++; if (bus.op_in_vld !== 2'b00) begin errors++; $display("FAIL reset_in_vld got=%b exp=00", bus.op_in_vld); end
        checks++; if (bus.vld_user2interface !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", bus.vld_user2interface); end
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", op_ap_start); end
        checks++; if (bus.in_level !== 10'd0 || bus.out_level !== 5'd0) begin errors++; $display("FAIL reset_levels got=%h/%h exp=0/0", bus.in_level, bus.out_level); end
    endtask
    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            bus.dout_leaf_interface2user[31:0] = 32'(i);
            bus.vld_interface2user[0] = 1;
            checks++; if (bus.ack_user2interface[0] !== 1'b1) begin errors++; $display("FAIL fill_ack word=%0d got=%b exp=1", i, bus.ack_user2interface[0]); end
            tick();
        end
        bus.vld_interface2user[0] = 0;
        checks++; if (bus.ack_user2interface[0] !== 1'b0) begin errors++; $display("FAIL full_ack got=%b exp=0", bus.ack_user2interface[0]); end
        checks++; if (bus.in_level[4:0] !== 5'd16) begin errors++; $display("FAIL full_level got=%0d exp=16", bus.in_level[4:0]); end
        checks++; if (bus.op_in_vld[0] !== 1'b1 || bus.op_in_data[31:0] !== 32'h1) begin errors++; $display("FAIL full_head got=%b/%h exp=1/00000001", bus.op_in_vld[0], bus.op_in_data[31:0]); end
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL fill_start got=%b exp=0", op_ap_start); end
    endtask
    task automatic test_full_rw;
        bus.dout_leaf_interface2user[31:0] = 32'hAA;
        bus.vld_interface2user[0] = 1;
        bus.op_in_ack[0] = 1;
        checks++; if (bus.ack_user2interface[0] !== 1'b0) begin errors++; $display("FAIL rw_ack_pre got=%b exp=0", bus.ack_user2interface[0]); end
        tick();
        bus.vld_interface2user[0] = 0;
        bus.op_in_ack[0] = 0;
        checks++; if (bus.in_level[4:0] !== 5'd15) begin errors++; $display("FAIL rw_level got=%0d exp=15", bus.in_level[4:0]); end
        checks++; if (bus.ack_user2interface[0] !== 1'b1) begin errors++; $display("FAIL rw_ack_post got=%b exp=1", bus.ack_user2interface[0]); end
    endtask
    task automatic test_drain;
        bus.op_in_ack[0] = 1;
        for (int i = 2; i <= 16; i++) begin
            checks++; if (bus.op_in_vld[0] !== 1'b1 || bus.op_in_data[31:0] !== 32'(i)) begin errors++; $display("FAIL drain_word idx=%0d got=%b/%h exp=1/%h", i, bus.op_in_vld[0], bus.op_in_data[31:0], 32'(i)); end
            tick();
        end
        bus.op_in_ack[0] = 0;
        checks++; if (bus.op_in_vld[0] !== 1'b0 || bus.in_level[4:0] !== 5'd0) begin errors++; $display("FAIL drain_empty got=%b/%0d exp=0/0", bus.op_in_vld[0], bus.in_level[4:0]); end
    endtask
    task automatic test_autostart;
        op_ap_done = 1;
        tick();
        op_ap_done = 0;
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", op_ap_start); end
        bus.dout_leaf_interface2user[31:0] = 32'h11;
        bus.vld_interface2user[0] = 1;
        tick();
        bus.vld_interface2user[0] = 0;
        repeat (2) tick();
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL one_port_start got=%b exp=0", op_ap_start); end
        bus.dout_leaf_interface2user[63:32] = 32'h22;
        bus.vld_interface2user[1] = 1;
        tick();
        bus.vld_interface2user[1] = 0;
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL start_early got=%b exp=0", op_ap_start); end
        tick();
        checks++; if (op_ap_start !== 1'b1) begin errors++; $display("FAIL start_fire got=%b exp=1", op_ap_start); end
        tick();
        checks++; if (op_ap_start !== 1'b1) begin errors++; $display("FAIL start_hold got=%b exp=1", op_ap_start); end
        op_ap_done = 1;
        tick();
        op_ap_done = 0;
        checks++; if (op_ap_start !== 1'b0) begin errors++; $display("FAIL done_drop got=%b exp=0", op_ap_start); end
        tick();
        checks++; if (op_ap_start !== 1'b1) begin errors++; $display("FAIL refire got=%b exp=1", op_ap_start); end
        checks++; if (bus.op_in_data !== {32'h22, 32'h11}) begin errors++; $display("FAIL start_heads got=%h exp=0000002200000011", bus.op_in_data); end
        op_ap_done = 1;
        bus.op_in_ack = 2'b11;
        tick();
        op_ap_done = 0;
        bus.op_in_ack = 2'b00;
        tick();
        checks++; if (op_ap_start !== 1'b0 || bus.in_level !== 10'd0) begin errors++; $display("FAIL start_end got=%b/%h exp=0/0", op_ap_start, bus.in_level); end
    endtask
    task automatic test_flush;
        for (int i = 0; i < 7; i++) begin
            bus.dout_leaf_interface2user[31:0] = 32'h100 + 32'(i);
            bus.vld_interface2user[0] = 1;
            tick();
        end
        checks++; if (bus.in_level[4:0] !== 5'd7) begin errors++; $display("FAIL pre_flush_level got=%0d exp=7", bus.in_level[4:0]); end
        bus.dout_leaf_interface2user[31:0] = 32'h55;
        flush = 1;
        tick();
        flush = 0;
        bus.vld_interface2user[0] = 0;
        checks++; if (bus.in_level[4:0] !== 5'd0 || bus.op_in_vld[0] !== 1'b0) begin errors++; $display("FAIL flush_level got=%0d/%b exp=0/0", bus.in_level[4:0], bus.op_in_vld[0]); end
        checks++; if (bus.ack_user2interface !== 2'b11 || op_ap_start !== 1'b0) begin errors++; $display("FAIL flush_ack got=%b/%b exp=11/0", bus.ack_user2interface, op_ap_start); end
        bus.dout_leaf_interface2user[31:0] = 32'h77;
        bus.vld_interface2user[0] = 1;
        tick();
        bus.vld_interface2user[0] = 0;
        checks++; if (bus.op_in_data[31:0] !== 32'h77 || bus.in_level[4:0] !== 5'd1) begin errors++; $display("FAIL flush_after got=%h/%0d exp=00000077/1", bus.op_in_data[31:0], bus.in_level[4:0]); end
        bus.op_in_ack[0] = 1;
        tick();
        bus.op_in_ack[0] = 0;
    endtask
    task automatic test_output;
        logic [31:0] words [2];
        logic [31:0] rx [4];
        int sent, got;
        words[0] = 32'hDEAD;
        words[1] = 32'hBEEF;
        sent = 0;
        got = 0;
        for (int n = 0; n < 8; n++) begin
            bus.ack_interface2user[0] = (n % 2 == 0);
            bus.op_out_vld[0] = sent < 2;
            bus.op_out_data = (sent < 2) ? words[sent] : 32'h0;
            #1;
            if (bus.vld_user2interface[0] && bus.ack_interface2user[0] && got < 4) begin
                rx[got] = bus.din_leaf_user2interface;
                got++;
            end
            if (bus.op_out_vld[0] && bus.op_out_ack[0]) sent++;
            tick();
        end
        bus.op_out_vld[0] = 0;
        bus.ack_interface2user[0] = 0;
        checks++; if (got !== 2) begin errors++; $display("FAIL out_count got=%0d exp=2", got); end
        checks++; if (got > 0 && rx[0] !== 32'hDEAD) begin errors++; $display("FAIL out_word0 got=%h exp=0000dead", rx[0]); end
        checks++; if (got > 1 && rx[1] !== 32'hBEEF) begin errors++; $display("FAIL out_word1 got=%h exp=0000beef", rx[1]); end
        checks++; if (bus.out_level !== 5'd0 || bus.vld_user2interface !== 1'b0) begin errors++; $display("FAIL out_empty got=%0d/%b exp=0/0", bus.out_level, bus.vld_user2interface); end
    endtask
    initial begin
        reset = 1;
        flush = 0;
        ap_start = 0;
        op_ap_done = 0;
        bus.dout_leaf_interface2user = '0;
        bus.vld_interface2user = '0;
        bus.op_in_ack = '0;
        bus.op_out_data = '0;
        bus.op_out_vld = '0;
        bus.ack_interface2user = '0;
        #1;
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_autostart();
        test_flush();
        test_output();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
